// File: rtl/ss_pkg.sv
// Shared types and the seven-segment inverse mapping for the segment-bus reader.
// Latency: combinational helpers only.
// Backpressure: not applicable (no handshakes in this package).
package ss_pkg;

  // Active-low segment pattern, bit0 = a .. bit6 = g.
  typedef logic [6:0] seg_t;

  localparam seg_t SEG_0     = 7'b1000000;
  localparam seg_t SEG_1     = 7'b1111001;
  localparam seg_t SEG_2     = 7'b0100100;
  localparam seg_t SEG_3     = 7'b0110000;
  localparam seg_t SEG_4     = 7'b0011001;
  localparam seg_t SEG_5     = 7'b0010010;
  localparam seg_t SEG_6     = 7'b0000010;
  localparam seg_t SEG_7     = 7'b1111000;
  localparam seg_t SEG_8     = 7'b0000000;
  localparam seg_t SEG_9     = 7'b0010000;
  localparam seg_t SEG_A     = 7'b0001000;
  localparam seg_t SEG_B     = 7'b0000011;
  localparam seg_t SEG_C     = 7'b1000110;
  localparam seg_t SEG_D     = 7'b0100001;
  localparam seg_t SEG_E     = 7'b0000110;
  localparam seg_t SEG_F     = 7'b0001110;
  localparam seg_t SEG_BLANK = 7'b1111111;

  // Returns {err, nibble}. Anything outside the hex glyph set (blank included)
  // decodes to nibble 0 with err set.
  function automatic logic [4:0] seg_to_nibble(input seg_t seg);
    logic [4:0] r;
    case (seg)
      SEG_0:   r = 5'h00;
      SEG_1:   r = 5'h01;
      SEG_2:   r = 5'h02;
      SEG_3:   r = 5'h03;
      SEG_4:   r = 5'h04;
      SEG_5:   r = 5'h05;
      SEG_6:   r = 5'h06;
      SEG_7:   r = 5'h07;
      SEG_8:   r = 5'h08;
      SEG_9:   r = 5'h09;
      SEG_A:   r = 5'h0A;
      SEG_B:   r = 5'h0B;
      SEG_C:   r = 5'h0C;
      SEG_D:   r = 5'h0D;
      SEG_E:   r = 5'h0E;
      SEG_F:   r = 5'h0F;
      default: r = 5'h10;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ss_inverse_lut.sv
// Combinational segment-pattern to hex-nibble decoder with invalid-glyph flag.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows input.
// Ports: seg (active-low pattern in), nibble (decoded value), err (pattern not a hex glyph).
module ss_inverse_lut
  import ss_pkg::*;
(
  input  seg_t       seg,
  output logic [3:0] nibble,
  output logic       err
);

  logic [4:0] dec;

  assign dec    = seg_to_nibble(seg);
  assign err    = dec[4];
  assign nibble = dec[3:0];

endmodule

// File: rtl/ss_scan_reader.sv
// Reads a multiplexed active-low seven-segment bus and emits one packed hex frame per full scan.
// Latency: stable pins -> digit capture 2+STABLE_CYCLES cycles; last capture -> frame_valid_o +1.
// Backpressure: frame held stable until frame_ready_i; a frame completing while one is held is dropped (overrun_o, sticky).
// Ports: clk, rst_n (async active-low); seg_n_i / dig_en_n_i asynchronous pin inputs;
//   frame_o/err_o/frame_valid_o/frame_ready_i output handshake; overrun_o sticky drop flag;
//   timeout_o one-cycle pulse when a partial frame is discarded.
// Build option SS_SCAN_READER_DP_EN adds dp_n_i (decimal point pin) and dp_o (captured DP per digit).
module ss_scan_reader
  import ss_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    rst_n,
`ifdef SS_SCAN_READER_DP_EN
  input  logic                    dp_n_i,
  output logic [NUM_DIGITS-1:0]   dp_o,
`endif
  input  logic [6:0]              seg_n_i,
  input  logic [NUM_DIGITS-1:0]   dig_en_n_i,
  output logic [4*NUM_DIGITS-1:0] frame_o,
  output logic [NUM_DIGITS-1:0]   err_o,
  output logic                    frame_valid_o,
  input  logic                    frame_ready_i,
  output logic                    overrun_o,
  output logic                    timeout_o
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [NUM_DIGITS-1:0] ALL_SEEN = '1;

  typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, HOLD} state_t;

  // Two-flop synchronisers; reset to "bus idle" so release cannot look like a digit.
  seg_t                  seg_s1, seg_s2;
  logic [NUM_DIGITS-1:0] en_s1, en_s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_s1 <= SEG_BLANK;
      seg_s2 <= SEG_BLANK;
      en_s1  <= '1;
      en_s2  <= '1;
    end else begin
      seg_s1 <= seg_n_i;
      seg_s2 <= seg_s1;
      en_s1  <= dig_en_n_i;
      en_s2  <= en_s1;
    end
  end

  // A sample is usable only when exactly one enable is low.
  logic [NUM_DIGITS-1:0] en_low;
  logic                  sample_ok;

  assign en_low    = ~en_s2;
  assign sample_ok = (en_low != '0) && ((en_low & (en_low - NUM_DIGITS'(1))) == '0);

  // Previous-cycle sample, used for the stability compare and as the capture source.
  seg_t                  last_seg;
  logic [NUM_DIGITS-1:0] last_en;
  logic                  same;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_seg <= SEG_BLANK;
      last_en  <= '1;
    end else begin
      last_seg <= seg_s2;
      last_en  <= en_s2;
    end
  end

`ifdef SS_SCAN_READER_DP_EN
  logic                  dp_s1, dp_s2, last_dp;
  logic [NUM_DIGITS-1:0] slot_dp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dp_s1   <= 1'b1;
      dp_s2   <= 1'b1;
      last_dp <= 1'b1;
    end else begin
      dp_s1   <= dp_n_i;
      dp_s2   <= dp_s1;
      last_dp <= dp_s2;
    end
  end

  assign same = (seg_s2 == last_seg) && (en_s2 == last_en) && (dp_s2 == last_dp);
`else
  assign same = (seg_s2 == last_seg) && (en_s2 == last_en);
`endif

  // Settle FSM: count identical consecutive samples, capture once, then wait for a change.
  state_t          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic            cap_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    cap_en  = 1'b0;
    case (state_q)
      IDLE: begin
        count_d = '0;
        if (sample_ok) begin
          state_d = SETTLE;
          count_d = CW'(1);
        end
      end
      SETTLE: begin
        if (!sample_ok) begin
          state_d = IDLE;
          count_d = '0;
        end else if (!same) begin
          count_d = CW'(1);
        end else if (count_q == CW'(STABLE_CYCLES - 1)) begin
          // This sample makes STABLE_CYCLES identical in a row.
          state_d = CAPTURE;
          count_d = '0;
        end else begin
          count_d = count_q + CW'(1);
        end
      end
      CAPTURE, HOLD: begin
        cap_en = (state_q == CAPTURE);
        if (!sample_ok) begin
          state_d = IDLE;
          count_d = '0;
        end else if (!same) begin
          state_d = SETTLE;
          count_d = CW'(1);
        end else begin
          state_d = HOLD;
        end
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase
  end

  // Decode of the captured (stable) pattern.
  logic [3:0] lut_nib;
  logic       lut_err;

  ss_inverse_lut u_lut (
    .seg    (last_seg),
    .nibble (lut_nib),
    .err    (lut_err)
  );

  // Capture slots, seen mask and partial-frame timeout.
  logic [4*NUM_DIGITS-1:0] slot_nib;
  logic [NUM_DIGITS-1:0]   slot_err;
  logic [NUM_DIGITS-1:0]   seen;
  logic [TW-1:0]           to_cnt;
  logic                    complete;
  logic                    load;

  assign complete = (seen == ALL_SEEN);
  assign load     = complete && (!frame_valid_o || frame_ready_i);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_nib  <= '0;
      slot_err  <= '0;
      seen      <= '0;
      to_cnt    <= '0;
      timeout_o <= 1'b0;
    end else begin
      timeout_o <= 1'b0;
      if (cap_en) begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
          if (!last_en[i]) begin
            slot_nib[4*i +: 4] <= lut_nib;
            slot_err[i]        <= lut_err;
          end
        end
      end

      if (complete) begin
        seen <= '0;
      end else if (cap_en) begin
        seen <= seen | ~last_en;
      end else if (seen != '0 && to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
        seen <= '0;
      end

      // Clearing at the threshold keeps the counter from ever wrapping.
      if (cap_en || complete || seen == '0) begin
        to_cnt <= '0;
      end else if (to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
        to_cnt    <= '0;
        timeout_o <= 1'b1;
      end else begin
        to_cnt <= to_cnt + TW'(1);
      end
    end
  end

`ifdef SS_SCAN_READER_DP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_dp <= '0;
      dp_o    <= '0;
    end else begin
      if (cap_en) begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
          if (!last_en[i]) slot_dp[i] <= ~last_dp;
        end
      end
      if (load) dp_o <= slot_dp;
    end
  end
`endif

  // Output register: a completed frame either loads or is dropped as an overrun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_o       <= '0;
      err_o         <= '0;
      frame_valid_o <= 1'b0;
      overrun_o     <= 1'b0;
    end else begin
      if (load) begin
        frame_o       <= slot_nib;
        err_o         <= slot_err;
        frame_valid_o <= 1'b1;
      end else if (frame_valid_o && frame_ready_i) begin
        frame_valid_o <= 1'b0;
      end
      if (complete && !load) overrun_o <= 1'b1;
    end
  end

endmodule
